// File: rtl/ctrl_pipe.sv
// Pipelined control unit for the 5-stage RV64 core: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use hazard, branch flush, freeze handling. `CTRL_IALU_EN` enables I-ALU decode.
module ctrl_pipe #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  ext_stall,
    input  logic                  branch_taken_ex,
    output logic                  ex_branch,
    output logic                  ex_aluSrc,
    output logic [1:0]            ex_aluOp,
    output logic                  ex_memRead,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_memRead,
    output logic                  mem_memWrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_regWrite,
    output logic                  wb_memToReg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic [1:0] aluOp;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
    } ctrlBundle_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
`ifdef CTRL_IALU_EN
    localparam logic [6:0] OpIAlu   = 7'b0010011;
`endif

    // Decode
    ctrlBundle_t decCtrl;
    logic        decValid;
    logic        usesRs2;

    always_comb begin
        decCtrl  = '0;
        decValid = 1'b0;
        usesRs2  = 1'b0;
        case (opcode_id)
            OpLoad: begin
                decCtrl  = ctrlBundle_t'(8'b0_1_1_00_0_1_1);
                decValid = 1'b1;
            end
            OpStore: begin
                decCtrl  = ctrlBundle_t'(8'b0_0_0_00_1_1_0);
                decValid = 1'b1;
                usesRs2  = 1'b1;
            end
            OpRType: begin
                decCtrl  = ctrlBundle_t'(8'b0_0_0_10_0_0_1);
                decValid = 1'b1;
                usesRs2  = 1'b1;
            end
            OpBranch: begin
                decCtrl  = ctrlBundle_t'(8'b1_0_0_01_0_0_0);
                decValid = 1'b1;
                usesRs2  = 1'b1;
            end
`ifdef CTRL_IALU_EN
            OpIAlu: begin
                decCtrl  = ctrlBundle_t'(8'b0_0_0_11_0_1_1);
                decValid = 1'b1;
            end
`endif
            default: begin
                decCtrl  = '0;
                decValid = 1'b0;
                usesRs2  = 1'b0;
            end
        endcase
    end

    // Stage registers
    ctrlBundle_t           exCtrlQ, exCtrlD;
    logic [REG_ADDR_W-1:0] exRdQ, exRdD;
    logic                  memMemReadQ, memMemWriteQ, memMemToRegQ, memRegWriteQ;
    logic [REG_ADDR_W-1:0] memRdQ;
    logic                  wbRegWriteQ, wbMemToRegQ;
    logic [REG_ADDR_W-1:0] wbRdQ;
    logic [CNT_W-1:0]      stallCntQ, stallCntD;
    logic [CNT_W-1:0]      flushCntQ, flushCntD;

    logic loadUse;
    logic advance;
    logic idExBubble;
    logic stallInc;
    logic flushInc;

    assign loadUse = exCtrlQ.memRead && (exRdQ != '0) &&
                     ((exRdQ == rs1_id) || (usesRs2 && (exRdQ == rs2_id)));

    // Freeze beats flush beats load-use stall.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        hazard_stall = 1'b0;
        advance      = 1'b1;
        idExBubble   = 1'b0;
        stallInc     = 1'b0;
        flushInc     = 1'b0;
        if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            advance    = 1'b0;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idExBubble = 1'b1;
            flushInc   = 1'b1;
        end else if (loadUse) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            hazard_stall = 1'b1;
            idExBubble   = 1'b1;
            stallInc     = 1'b1;
        end
    end

    // Unrecognised opcodes become bubbles, rd included.
    always_comb begin
        if (idExBubble || !decValid) begin
            exCtrlD = '0;
            exRdD   = '0;
        end else begin
            exCtrlD = decCtrl;
            exRdD   = rd_id;
        end
    end

    always_comb begin
        stallCntD = stallCntQ;
        flushCntD = flushCntQ;
        if (stallInc && (stallCntQ != '1)) begin
            stallCntD = stallCntQ + CNT_W'(1);
        end
        if (flushInc && (flushCntQ != '1)) begin
            flushCntD = flushCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exCtrlQ      <= '0;
            exRdQ        <= '0;
            memMemReadQ  <= 1'b0;
            memMemWriteQ <= 1'b0;
            memMemToRegQ <= 1'b0;
            memRegWriteQ <= 1'b0;
            memRdQ       <= '0;
            wbRegWriteQ  <= 1'b0;
            wbMemToRegQ  <= 1'b0;
            wbRdQ        <= '0;
        end else if (advance) begin
            exCtrlQ      <= exCtrlD;
            exRdQ        <= exRdD;
            memMemReadQ  <= exCtrlQ.memRead;
            memMemWriteQ <= exCtrlQ.memWrite;
            memMemToRegQ <= exCtrlQ.memToReg;
            memRegWriteQ <= exCtrlQ.regWrite;
            memRdQ       <= exRdQ;
            wbRegWriteQ  <= memRegWriteQ;
            wbMemToRegQ  <= memMemToRegQ;
            wbRdQ        <= memRdQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign ex_branch    = exCtrlQ.branch;
    assign ex_aluSrc    = exCtrlQ.aluSrc;
    assign ex_aluOp     = exCtrlQ.aluOp;
    assign ex_memRead   = exCtrlQ.memRead;
    assign ex_rd        = exRdQ;
    assign mem_memRead  = memMemReadQ;
    assign mem_memWrite = memMemWriteQ;
    assign mem_rd       = memRdQ;
    assign wb_regWrite  = wbRegWriteQ;
    assign wb_memToReg  = wbMemToRegQ;
    assign wb_rd        = wbRdQ;
    assign stall_cnt    = stallCntQ;
    assign flush_cnt    = flushCntQ;

endmodule
